// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and constants; WORD_W is also used by decode and the register file.
package if_fetch_stage_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP_DEF   = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: rst > flush > freeze > load.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              load,
  input  logic [WORD_W-1:0] instr,
  input  logic [WORD_W-1:0] pc,
  input  logic              valid,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pc_o,
  output logic              valid_o
);
  logic [WORD_W-1:0] instr_q, pc_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (!freeze && load) begin
      instr_q <= instr;
      valid_q <= valid;
      // a bubble keeps the last pc so decode sees a stable value
      if (valid) pc_q <= pc;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, imem handshake, branch redirect with deferred kill, skid buffer, IF/ID.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [WORD_W-1:0] PC_STEP   = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              br_taken,
  input  logic [WORD_W-1:0] br_addr,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instruction_out,
  output logic [WORD_W-1:0] pc_out,
  output logic              valid_out
);
  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d, target_q, target_d;
  logic [WORD_W-1:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
  logic              kill_q, kill_d;
  logic [WORD_W-1:0] seq_pc, ld_instr, ld_pc;
  logic              ld_valid;

  assign seq_pc = addr_q + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= RESET_PC;
      kill_q       <= 1'b0;
      target_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      addr_q       <= addr_d;
      kill_q       <= kill_d;
      target_q     <= target_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    kill_d       = kill_q;
    target_d     = target_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (state_q == FETCH) begin
      if (br_taken) begin
        if (imem_ready) begin
          addr_d = br_addr;
          kill_d = 1'b0;
        end else begin
          // imem_addr must stay stable, so the redirect waits for the response
          kill_d   = 1'b1;
          target_d = br_addr;
        end
      end else if (imem_ready) begin
        if (kill_q) begin
          addr_d = target_q;
          kill_d = 1'b0;
        end else begin
          addr_d = seq_pc;
          if (freeze) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = seq_pc;
            state_d      = HOLD;
          end
        end
      end
    end else begin
      if (br_taken) begin
        addr_d  = br_addr;
        state_d = FETCH;
      end else if (!freeze) begin
        state_d = FETCH;
      end
    end
  end

  always_comb begin
    imem_req  = (state_q == FETCH) && !rst;
    imem_addr = addr_q;
    ld_instr  = NOP_INSTR;
    ld_pc     = seq_pc;
    ld_valid  = 1'b0;
    if (state_q == HOLD) begin
      ld_instr = skid_instr_q;
      ld_pc    = skid_pc_q;
      ld_valid = 1'b1;
    end else if (imem_ready && !kill_q) begin
      ld_instr = imem_rdata;
      ld_valid = 1'b1;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .flush  (br_taken),
    .freeze (freeze),
    .load   (1'b1),
    .instr  (ld_instr),
    .pc     (ld_pc),
    .valid  (ld_valid),
    .instr_o(instruction_out),
    .pc_o   (pc_out),
    .valid_o(valid_out)
  );
endmodule
